pad_line_ctrl: RTL and testbench

- Synchronous controller for one bidirectional CMOS IO pad line in the ETROC2 periphery.
- Drives the pad's core-side controls: A, OUT_EN, DS, PEN and UD.
- Samples the pad's Schmitt-trigger input Z_h.
- Transmits a WIDTH-bit word MSB-first. Optionally turns the line around and receives a WIDTH-bit reply.
- While idle, the line is released with the pad's weak pull-up enabled.

---
 rtl/pad_line_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pad_line_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_line_ctrl.sv
// pad_line_ctrl: drives the core side of one ETROC2 bidirectional CMOS pad.
// Sends a word MSB-first, optionally turns the line around and receives a reply.
module pad_line_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DIV      = 4,
    parameter int TURN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_rd,
    input  logic             ds_cfg,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             pad_A,
    output logic             pad_OUT_EN,
    output logic             pad_DS,
    output logic             pad_PEN,
    output logic             pad_UD,
    input  logic             pad_Z_h
);
    localparam int DW = $clog2(DIV);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    typedef enum logic [1:0] {IDLE, TX, TURN, RX} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-2:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_word;
    logic             rd_q, rd_d;
    logic             ds_q, ds_d;
    logic             a_q, a_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic             pen_q, pen_d;
    logic             ud_q;
    logic             z_meta_q, z_s_q;

    // Only the MSB-aligned W-1 history bits are kept; the newest bit is appended on capture.
    assign rx_word = {rx_sh_q, z_s_q};

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        turn_d     = turn_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rd_d       = rd_q;
        ds_d       = ds_q;
        a_d        = a_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d = TX;
                    a_d     = tx_data[WIDTH-1];
                    tx_sh_d = {tx_data[WIDTH-2:0], 1'b0};
                    rd_d    = tx_rd;
                    ds_d    = ds_cfg;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            TX: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        turn_d  = '0;
                        a_d     = 1'b1;
                        state_d = rd_q ? TURN : IDLE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        a_d     = tx_sh_q[WIDTH-1];
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    turn_d  = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = RX;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            RX: begin
                // Sample at the end of each bit period, well after the synchroniser settles.
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    rx_sh_d = rx_word[WIDTH-2:0];
                    if (bit_q == BIT_LAST) begin
                        bit_d      = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pad controls are registered from the next state so they line up with it.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        oe_d    = (state_d == TX);
        pen_d   = (state_d != TX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            turn_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rd_q       <= 1'b0;
            ds_q       <= 1'b0;
            a_q        <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            pen_q      <= 1'b1;
            ud_q       <= 1'b1;
            z_meta_q   <= 1'b1;
            z_s_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            turn_q     <= turn_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rd_q       <= rd_d;
            ds_q       <= ds_d;
            a_q        <= a_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            pen_q      <= pen_d;
            ud_q       <= 1'b1;
            z_meta_q   <= pad_Z_h;
            z_s_q      <= z_meta_q;
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign pad_A      = a_q;
    assign pad_OUT_EN = oe_q;
    assign pad_DS     = ds_q;
    assign pad_PEN    = pen_q;
    assign pad_UD     = ud_q;

endmodule

// File: tb/tb_pad_line_ctrl.sv
// Directed bench for pad_line_ctrl: scoreboards for transmitted words and received replies,
// with latency and boundary checks taken on the falling clock edge.
module tb_pad_line_ctrl;
    localparam int W        = 8;
    localparam int DIV      = 4;
    localparam int TURN_CYC = 2;
    localparam int TXC      = W * DIV;

    typedef struct {
        logic [W-1:0] data;
        logic         ds;
    } tx_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_rd = 1'b0;
    logic         ds_cfg = 1'b0;
    logic         pad_Z_h = 1'b1;
    logic         tx_ready, rx_valid, busy;
    logic [W-1:0] rx_data;
    logic         pad_A, pad_OUT_EN, pad_DS, pad_PEN, pad_UD;

    pad_line_ctrl #(.WIDTH(W), .DIV(DIV), .TURN_CYC(TURN_CYC)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_rd(tx_rd), .ds_cfg(ds_cfg),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .pad_A(pad_A), .pad_OUT_EN(pad_OUT_EN), .pad_DS(pad_DS),
        .pad_PEN(pad_PEN), .pad_UD(pad_UD), .pad_Z_h(pad_Z_h)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int ncyc = 0;
    int zbase = 1 << 30;
    logic [W-1:0] zword = '0;
    tx_exp_t exp_tx[$];
    logic [W-1:0] exp_rx[$];

    // Line monitor state
    int oe_run = 0, oe_total = 0, oe_first = 0, oe_last = 0;
    int rxv_cnt = 0, rxv_at = 0;
    logic oe_prev = 1'b0, rxv_prev = 1'b0, cur_bit = 1'b1, ds_seen = 1'b0;
    logic [W-1:0] word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge, drive the reply line, run the scoreboards.
    task automatic tick();
        tx_exp_t e;
        @(negedge clk);
        ncyc++;
        if (ncyc >= zbase && ncyc < zbase + TXC) pad_Z_h = zword[W-1-((ncyc-zbase)/DIV)];
        else pad_Z_h = 1'b1;

        chk("busy_vs_ready", busy, !tx_ready);
        if (pad_OUT_EN) chk("oe_with_pen", pad_PEN, 1'b0);

        if (rst) begin
            oe_run  = 0;
            oe_prev = 1'b0;
        end else begin
            if (pad_OUT_EN) begin
                if (!oe_prev) oe_first = ncyc;
                oe_last = ncyc;
                if (oe_run % DIV == 0) begin
                    cur_bit = pad_A;
                    word    = {word[W-2:0], pad_A};
                end else begin
                    chk("a_hold", pad_A, cur_bit);
                end
                ds_seen = pad_DS;
                oe_run++;
                oe_total++;
            end else if (oe_prev) begin
                chk("oe_len", oe_run, TXC);
                chk("tx_sb_nonempty", exp_tx.size() != 0, 1'b1);
                if (exp_tx.size() != 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_word", word, e.data);
                    chk("tx_ds", ds_seen, e.ds);
                end
                oe_run = 0;
            end
            oe_prev = pad_OUT_EN;
        end

        if (rx_valid) begin
            rxv_cnt++;
            rxv_at = ncyc;
            chk("rx_pulse_width", rxv_prev, 1'b0);
            chk("rx_sb_nonempty", exp_rx.size() != 0, 1'b1);
            if (exp_rx.size() != 0) chk("rx_word", rx_data, exp_rx.pop_front());
        end
        rxv_prev = rx_valid;
    endtask

    // Present a request and return the cycle index of its accept edge.
    task automatic send(input logic [W-1:0] d, input logic rd, input logic ds, output int e);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_rd    = rd;
        ds_cfg   = ds;
        for (int i = 0; i < 200 && !tx_ready; i++) tick();
        chk("accept_ready", tx_ready, 1'b1);
        e = ncyc;
        exp_tx.push_back('{d, ds});
        if (rd) exp_rx.push_back(zword);
    endtask

    task automatic wait_ready();
        int k = 0;
        do begin
            tick();
            k++;
            if (k == 1) tx_valid = 1'b0;
        end while (!tx_ready && k < 2000);
        chk("ready_timeout", tx_ready, 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, tx_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_oe"}, pad_OUT_EN, 1'b0);
        chk({tag, "_pen"}, pad_PEN, 1'b1);
        chk({tag, "_ud"}, pad_UD, 1'b1);
        chk({tag, "_a"}, pad_A, 1'b1);
        chk({tag, "_rxv"}, rx_valid, 1'b0);
        chk({tag, "_rxd"}, rx_data, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2;

        // Reset values
        repeat (3) tick();
        chk_idle("rst");
        chk("rst_ds", pad_DS, 1'b0);

        // Request presented during the last reset cycle is accepted only after release
        tx_valid = 1'b1; tx_data = 8'h81; tx_rd = 1'b0; ds_cfg = 1'b0;
        tick();
        chk("rel_oe_held", pad_OUT_EN, 1'b0);
        rst = 1'b0;
        e = ncyc;
        exp_tx.push_back('{8'h81, 1'b0});
        tick();
        chk("rel_oe_rise", pad_OUT_EN, 1'b1);
        chk("rel_busy", busy, 1'b1);
        tx_valid = 1'b0;

        // Reset mid-TX for three cycles
        while (ncyc < e + 10) tick();
        rst = 1'b1;
        exp_tx.delete();
        tick();
        chk_idle("midtx_rst");
        tick(); tick();
        rst = 1'b0;
        tick();

        // Write 0xA5 at 16 mA; ds_cfg flips after accept and must not matter
        oe_total = 0; rxv_cnt = 0;
        send(8'hA5, 1'b0, 1'b1, e);
        tick();
        tx_valid = 1'b0; ds_cfg = 1'b0;
        wait_ready();
        chk("wr_ready_lat", ncyc - e, TXC + 1);
        chk("wr_oe_total", oe_total, TXC);
        chk("wr_oe_first", oe_first - e, 1);
        chk("wr_oe_last", oe_last - e, TXC);
        chk("wr_no_rxv", rxv_cnt, 0);

        // Read with turnaround, reply 0x96
        oe_total = 0; rxv_cnt = 0;
        zword = 8'h96;
        send(8'h3C, 1'b1, 1'b0, e);
        zbase = e + TXC + TURN_CYC + 1;
        wait_ready();
        zbase = 1 << 30;
        chk("rd_ready_lat", ncyc - e, 2 * TXC + TURN_CYC + 1);
        chk("rd_rxv_at", rxv_at - e, 2 * TXC + TURN_CYC + 1);
        chk("rd_rxv_cnt", rxv_cnt, 1);
        chk("rd_oe_last", oe_last - e, TXC);
        chk("rd_oe_total", oe_total, TXC);
        chk("rd_rx_data", rx_data, 8'h96);

        // Back-to-back with tx_valid held
        oe_total = 0;
        send(8'h01, 1'b0, 1'b0, e);
        tick();
        send(8'hFF, 1'b0, 1'b1, e2);
        chk("b2b_gap", e2 - e, TXC + 1);
        wait_ready();
        chk("b2b_ready_lat", ncyc - e2, TXC + 1);
        chk("b2b_oe_total", oe_total, 2 * TXC);

        // Request pulsed while busy is dropped
        oe_total = 0;
        send(8'h0F, 1'b0, 1'b0, e);
        tick();
        tx_valid = 1'b0;
        repeat (6) tick();
        tx_valid = 1'b1; tx_data = 8'h55;
        tick();
        tx_valid = 1'b0;
        wait_ready();
        chk("busy_ready_lat", ncyc - e, TXC + 1);
        repeat (4) tick();
        chk("busy_oe_total", oe_total, TXC);
        chk("busy_idle", busy, 1'b0);

        // Reset during bit 5 of RX discards the reply
        rxv_cnt = 0;
        zword = 8'h5A;
        send(8'hAA, 1'b1, 1'b0, e);
        zbase = e + TXC + TURN_CYC + 1;
        tick();
        tx_valid = 1'b0;
        while (ncyc < zbase + 5 * DIV) tick();
        rst = 1'b1;
        exp_rx.delete();
        tick();
        chk_idle("midrx_rst");
        tick(); tick();
        rst = 1'b0;
        zbase = 1 << 30;
        repeat (6) tick();
        chk("midrx_no_rxv", rxv_cnt, 0);
        chk("midrx_rxd", rx_data, '0);

        // Fresh read after the aborted one
        zword = 8'hC3;
        send(8'h12, 1'b1, 1'b0, e);
        zbase = e + TXC + TURN_CYC + 1;
        wait_ready();
        zbase = 1 << 30;
        chk("rd2_rxv_cnt", rxv_cnt, 1);
        chk("rd2_rxv_at", rxv_at - e, 2 * TXC + TURN_CYC + 1);
        chk("rd2_rx_data", rx_data, 8'hC3);
        repeat (3) tick();
        chk("sb_tx_drained", exp_tx.size(), 0);
        chk("sb_rx_drained", exp_rx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
